// File: rtl/calc_sequencer.sv
// Button sequencer for the 8-bit add/subtract datapath: turns button rises
// into load / operation-select / execute / show control for the datapath.
module calc_sequencer #(
    parameter int TIMEOUT_TICKS = 1000,
    parameter int CNT_W         = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_load,
    input  logic       btn_op,
    input  logic       btn_eq,
    input  logic       btn_clr,
    output logic       load,
    output logic       add_sub,
    output logic       select,
    output logic       done,
    output logic       busy,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        WAIT_B = 3'd2,
        EXEC   = 3'd3,
        SHOW   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_TICKS - 1);

    state_t           state, state_nx;
    logic             add_sub_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             btn_load_q, btn_op_q, btn_eq_q, btn_clr_q;
    logic             rise_load_p1, rise_op_p1, rise_eq_p1, rise_clr_p1;
    logic             any_rise, timeout_hit;

    // Stage p1: registered button rises; the _q copies reset high so a
    // button held through reset never produces an event.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_load_q   <= 1'b1;
            btn_op_q     <= 1'b1;
            btn_eq_q     <= 1'b1;
            btn_clr_q    <= 1'b1;
            rise_load_p1 <= 1'b0;
            rise_op_p1   <= 1'b0;
            rise_eq_p1   <= 1'b0;
            rise_clr_p1  <= 1'b0;
        end else begin
            btn_load_q   <= btn_load;
            btn_op_q     <= btn_op;
            btn_eq_q     <= btn_eq;
            btn_clr_q    <= btn_clr;
            rise_load_p1 <= btn_load & ~btn_load_q;
            rise_op_p1   <= btn_op & ~btn_op_q;
            rise_eq_p1   <= btn_eq & ~btn_eq_q;
            rise_clr_p1  <= btn_clr & ~btn_clr_q;
        end
    end

    assign any_rise    = rise_load_p1 | rise_op_p1 | rise_eq_p1 | rise_clr_p1;
    assign timeout_hit = tick && (cnt == CNT_LAST);

    always_comb begin
        state_nx   = state;
        add_sub_nx = add_sub;
        cnt_nx     = '0;
        if (rise_clr_p1) begin
            state_nx   = IDLE;
            add_sub_nx = 1'b1;
        end else begin
            case (state)
                IDLE:   if (rise_load_p1) state_nx = LOAD_A;
                LOAD_A: if (tick) state_nx = WAIT_B;
                WAIT_B, SHOW: begin
                    if (rise_op_p1) add_sub_nx = ~add_sub;
                    if (rise_load_p1)
                        state_nx = LOAD_A;
                    else if (rise_eq_p1 && state == WAIT_B)
                        state_nx = EXEC;
                    else if (!any_rise && timeout_hit)
                        state_nx = IDLE;
                    // Any button activity restarts the inactivity count.
                    if (any_rise || timeout_hit)
                        cnt_nx = '0;
                    else if (tick)
                        cnt_nx = cnt + 1'b1;
                    else
                        cnt_nx = cnt;
                end
                EXEC:    state_nx = SHOW;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Stage p2: state and outputs decoded from the next state, all registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            add_sub <= 1'b1;
            cnt     <= '0;
            load    <= 1'b0;
            select  <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nx;
            add_sub <= add_sub_nx;
            cnt     <= cnt_nx;
            load    <= (state_nx == LOAD_A);
            select  <= (state_nx == EXEC) || (state_nx == SHOW);
            done    <= (state_nx == EXEC);
            busy    <= (state_nx != IDLE);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer (TIMEOUT_TICKS = 4).
module tb_calc_sequencer;

    logic       clk = 1'b0;
    logic       reset, tick, btn_load, btn_op, btn_eq, btn_clr;
    logic       load, add_sub, select, done, busy;
    logic [2:0] state_o;
    int         n_checks = 0;
    int         n_pass   = 0;

    calc_sequencer #(.TIMEOUT_TICKS(4), .CNT_W(10)) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .btn_load(btn_load), .btn_op(btn_op), .btn_eq(btn_eq), .btn_clr(btn_clr),
        .load(load), .add_sub(add_sub), .select(select), .done(done),
        .busy(busy), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One tick pulse followed by two quiet cycles (tick every 3 clk).
    task automatic tick3();
        tick = 1'b1; cyc();
        tick = 1'b0; cyc(); cyc();
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0;
        btn_load = 1'b1; btn_op = 1'b0; btn_eq = 1'b0; btn_clr = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        cyc(); cyc(); cyc();
        chk("held_rst_state", state_o, 3'd0);
        chk("held_rst_load", load, 1'b0);
        chk("held_rst_addsub", add_sub, 1'b1);
        chk("held_rst_busy", busy, 1'b0);
        chk("held_rst_select", select, 1'b0);
        chk("held_rst_done", done, 1'b0);

        btn_load = 1'b0; cyc();
        btn_load = 1'b1; cyc();
        chk("latency_1clk_state", state_o, 3'd0);
        cyc();
        chk("loada_state", state_o, 3'd1);
        chk("loada_load", load, 1'b1);
        chk("loada_busy", busy, 1'b1);
        btn_load = 1'b0;

        // Load held through four more cycles, then the tick cycle.
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("loada_hold_load", load, 1'b1);
            chk("loada_hold_state", state_o, 3'd1);
        end
        tick = 1'b1;
        chk("tick_cycle_load", load, 1'b1);
        cyc();
        tick = 1'b0;
        chk("waitb_state", state_o, 3'd2);
        chk("waitb_load", load, 1'b0);
        chk("waitb_select", select, 1'b0);

        btn_op = 1'b1; cyc(); cyc();
        btn_op = 1'b0;
        chk("op_toggle_addsub", add_sub, 1'b0);
        chk("op_toggle_state", state_o, 3'd2);
        btn_eq = 1'b1; cyc();
        chk("pre_exec_done", done, 1'b0);
        cyc();
        chk("exec_state", state_o, 3'd3);
        chk("exec_done", done, 1'b1);
        chk("exec_select", select, 1'b1);
        cyc();
        btn_eq = 1'b0;
        chk("show_state", state_o, 3'd4);
        chk("show_done", done, 1'b0);
        chk("show_select", select, 1'b1);
        btn_op = 1'b1; cyc();
        chk("show_op_done_a", done, 1'b0);
        cyc();
        btn_op = 1'b0;
        chk("show_op_addsub", add_sub, 1'b1);
        chk("show_op_done_b", done, 1'b0);
        chk("show_op_state", state_o, 3'd4);

        // Reload from SHOW, then op and eq rising together in WAIT_B.
        btn_load = 1'b1; cyc(); cyc();
        btn_load = 1'b0;
        chk("reload_state", state_o, 3'd1);
        chk("reload_select", select, 1'b0);
        tick = 1'b1; cyc();
        tick = 1'b0;
        chk("reload_waitb", state_o, 3'd2);
        btn_op = 1'b1; btn_eq = 1'b1; cyc(); cyc();
        chk("opeq_state", state_o, 3'd3);
        chk("opeq_addsub", add_sub, 1'b0);
        chk("opeq_done", done, 1'b1);
        cyc();
        btn_op = 1'b0; btn_eq = 1'b0;
        chk("opeq_show", state_o, 3'd4);

        // Timeout in SHOW with a restart after the third tick.
        tick3(); tick3(); tick3();
        chk("to_pre_state", state_o, 3'd4);
        btn_op = 1'b1; cyc(); cyc();
        btn_op = 1'b0;
        chk("to_restart_addsub", add_sub, 1'b1);
        tick3(); tick3(); tick3();
        chk("to_restarted_state", state_o, 3'd4);
        tick = 1'b1; cyc();
        tick = 1'b0;
        chk("to_idle_state", state_o, 3'd0);
        chk("to_idle_select", select, 1'b0);
        chk("to_idle_busy", busy, 1'b0);
        chk("to_idle_addsub", add_sub, 1'b1);

        // Clear and eq together in WAIT_B.
        btn_load = 1'b1; cyc(); cyc();
        btn_load = 1'b0;
        tick = 1'b1; cyc();
        tick = 1'b0;
        chk("clr_setup_state", state_o, 3'd2);
        btn_op = 1'b1; cyc(); cyc();
        btn_op = 1'b0;
        chk("clr_setup_addsub", add_sub, 1'b0);
        btn_clr = 1'b1; btn_eq = 1'b1; cyc();
        chk("clr_done_a", done, 1'b0);
        cyc();
        chk("clr_state", state_o, 3'd0);
        chk("clr_addsub", add_sub, 1'b1);
        chk("clr_done_b", done, 1'b0);
        cyc();
        chk("clr_done_c", done, 1'b0);
        btn_clr = 1'b0; btn_eq = 1'b0;

        // Reset while loading.
        btn_load = 1'b1; cyc(); cyc();
        chk("rst_mid_load_pre", load, 1'b1);
        reset = 1'b1; cyc();
        chk("rst_mid_load", load, 1'b0);
        chk("rst_mid_state", state_o, 3'd0);
        chk("rst_mid_busy", busy, 1'b0);
        reset = 1'b0; cyc(); cyc();
        chk("rst_held_btn_state", state_o, 3'd0);
        btn_load = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Button-driven controller for the 8-bit add/subtract datapath with loadable operand register and display mux.
- Turns raw push-button levels into a fixed operation sequence: load operand A, choose the operation, execute, hold the result.
- Drives the datapath's `load`, `add_sub` and `select` controls.
- Sits between the board buttons and the datapath, clocked by the system clock. Uses the prescaled tick as a qualifier only.

Parameters:
- TIMEOUT_TICKS, 1000: number of `tick` pulses of button inactivity in WAIT_B or SHOW before returning to IDLE.
- CNT_W, 10: width of the timeout counter; must satisfy 2^CNT_W >= TIMEOUT_TICKS.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  one-clk-wide enable pulse; the datapath register samples `load` only on cycles where tick=1.
- btn_load  input  1  load-operand button, level, already synchronised.
- btn_op  input  1  operation-toggle button, level.
- btn_eq  input  1  execute button, level.
- btn_clr  input  1  clear button, level.
- load  output  1  operand-register load enable to datapath.
- add_sub  output  1  1 = add, 0 = subtract.
- select  output  1  display mux: 0 = switches, 1 = result.
- done  output  1  one-clk pulse when a result becomes valid.
- busy  output  1  high whenever state != IDLE.
- state_o  output  3  current state encoding.

Behaviour:
- Edge detection: each button is registered every clk into a `_q` copy. A rise is `btn & ~btn_q`; only rises are acted on.
  - The `_q` copies reset to 1, so a button held through reset produces no event.
- State encoding: IDLE=0, LOAD_A=1, WAIT_B=2, EXEC=3, SHOW=4. Other codes go to IDLE on the next clk.
- Reset values: state IDLE, load 0, add_sub 1, select 0, done 0, busy 0, timeout counter 0.
- btn_clr rise, any state: next state IDLE, add_sub←1, counter←0. It has priority over every other button in the same cycle, and over tick.
- IDLE:
  - select=0, load=0.
  - btn_load rise → LOAD_A.
  - btn_op and btn_eq are ignored.
- LOAD_A:
  - load=1, select=0.
  - Load is held until a cycle with tick=1. On that cycle load stays 1, so the datapath captures; next state is WAIT_B and load falls the cycle after.
  - All buttons except clr are ignored.
  - If the tick arrives on the same clk as entry, the state still lasts exactly that one cycle.
- WAIT_B:
  - select=0.
  - btn_op rise toggles add_sub.
  - btn_eq rise → EXEC.
  - btn_op and btn_eq rising in the same cycle: the toggle is applied and the state goes to EXEC, so EXEC sees the new add_sub.
  - btn_load rise → LOAD_A, which reloads operand A.
- EXEC:
  - Exactly one clk: select=1, done=1. Next state SHOW.
  - Buttons are ignored except clr.
- SHOW:
  - select=1, done=0.
  - btn_op rise toggles add_sub; the result updates combinationally and no new done pulse is issued.
  - btn_load rise → LOAD_A, with select dropping to 0 on entry.
  - btn_eq is ignored.
- Timeout, in WAIT_B and SHOW only:
  - The counter increments on tick.
  - It clears on any button rise, and on entry to WAIT_B or SHOW.
  - When counter == TIMEOUT_TICKS-1 and tick=1, next state is IDLE, counter←0, add_sub unchanged.
  - The counter holds 0 in all other states and never wraps.
- Output registration: all outputs are registered, with state_o mirroring state. Latency from a button rise to the output change is 2 clk (1 clk for edge capture, 1 clk for the state register).
- Reset asserted mid-sequence, including during LOAD_A with load=1, forces reset values on the next clk edge. No partial load is guaranteed to complete.

Test Plan:
- Reset with btn_load held high, then release reset → state stays IDLE, load=0, add_sub=1. Release and re-press btn_load → LOAD_A.
- btn_load pulse, tick arrives 5 clk later → load high continuously from LOAD_A entry through the tick cycle, low the next clk, state=2.
- In WAIT_B: btn_op rise, then btn_eq rise → add_sub=0, one-clk done with select=1, state=4. Then btn_op in SHOW → add_sub=1, no done pulse.
- btn_op and btn_eq rise on the same clk in WAIT_B → EXEC entered with add_sub already toggled.
- TIMEOUT_TICKS=4, in SHOW with no buttons, tick every 3 clk → IDLE on the 4th tick, select=0, busy=0. A btn_op rise after the 3rd tick restarts the count.
- btn_clr and btn_eq rise together in WAIT_B → IDLE, add_sub=1, done never asserted. Reset during LOAD_A → load=0 on the next clk.
